// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage handshake between the pipeline and the HI/LO multiply/divide sequencer.
// The master side is the pipeline (op presenter); the slave side is the sequencer.
interface hilo_muldiv_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  op_valid;
  logic [2:0]            op_code;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [DATA_WIDTH-1:0] hi_in;
  logic [DATA_WIDTH-1:0] lo_in;
  logic                  flush;
  logic                  stall_req;
  logic                  hilo_write_en;
  logic [DATA_WIDTH-1:0] hi_write_data;
  logic [DATA_WIDTH-1:0] lo_write_data;
  logic                  div_by_zero;

  modport master (
    output op_valid, op_code, operand_a, operand_b, hi_in, lo_in, flush,
    input  stall_req, hilo_write_en, hi_write_data, lo_write_data, div_by_zero
  );

  modport slave (
    input  op_valid, op_code, operand_a, operand_b, hi_in, lo_in, flush,
    output stall_req, hilo_write_en, hi_write_data, lo_write_data, div_by_zero
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: two-stall registered multiply, 32-step restoring divide, and
// zero-latency MTHI/MTLO. Sole producer of HI/LO write data in EX.
module hilo_muldiv_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  hilo_muldiv_ctrl_if.slave bus
);
  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(DATA_WIDTH - 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] opa_q, opb_q, rem_q, quo_q, hi_q, lo_q;
  logic                  sgn_q, qneg_q, rneg_q, dz_q;

  logic accept, acc_mul, acc_div, acc_mthi, acc_mtlo;
  assign accept   = (state_q == StIdle) && bus.op_valid && !bus.flush;
  assign acc_mul  = accept && ((bus.op_code == OpMult) || (bus.op_code == OpMultu));
  assign acc_div  = accept && ((bus.op_code == OpDiv) || (bus.op_code == OpDivu));
  assign acc_mthi = accept && (bus.op_code == OpMthi);
  assign acc_mtlo = accept && (bus.op_code == OpMtlo);

  // Operand magnitudes for signed DIV; the most negative value maps onto itself,
  // which the unsigned datapath handles correctly.
  logic                  div_signed, a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_abs, b_abs;
  assign div_signed = (bus.op_code == OpDiv);
  assign a_neg      = div_signed && bus.operand_a[DATA_WIDTH-1];
  assign b_neg      = div_signed && bus.operand_b[DATA_WIDTH-1];
  assign a_abs      = a_neg ? (DATA_WIDTH'(0) - bus.operand_a) : bus.operand_a;
  assign b_abs      = b_neg ? (DATA_WIDTH'(0) - bus.operand_b) : bus.operand_b;

  logic [2*DATA_WIDTH-1:0] ext_a, ext_b, product;
  assign ext_a   = {{DATA_WIDTH{sgn_q & opa_q[DATA_WIDTH-1]}}, opa_q};
  assign ext_b   = {{DATA_WIDTH{sgn_q & opb_q[DATA_WIDTH-1]}}, opb_q};
  assign product = ext_a * ext_b;

  // Restoring step: the extra top bit of the trial difference is its borrow.
  logic [DATA_WIDTH:0]   rem_sh, trial;
  logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;
  assign rem_sh  = {rem_q, quo_q[DATA_WIDTH-1]};
  assign trial   = rem_sh - {1'b0, opb_q};
  assign rem_nxt = trial[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
  assign quo_nxt = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else if (bus.flush) begin
      state_q <= StIdle;
      dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (acc_mul) begin
            opa_q   <= bus.operand_a;
            opb_q   <= bus.operand_b;
            sgn_q   <= (bus.op_code == OpMult);
            dz_q    <= 1'b0;
            state_q <= StMul;
          end else if (acc_div) begin
            quo_q  <= a_abs;
            rem_q  <= '0;
            opb_q  <= b_abs;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt_q  <= '0;
            if (bus.operand_b == '0) begin
              hi_q    <= bus.operand_a;
              lo_q    <= '1;
              dz_q    <= 1'b1;
              state_q <= StDone;
            end else begin
              dz_q    <= 1'b0;
              state_q <= StDiv;
            end
          end
        end
        StMul: begin
          hi_q    <= product[2*DATA_WIDTH-1:DATA_WIDTH];
          lo_q    <= product[DATA_WIDTH-1:0];
          state_q <= StDone;
        end
        StDiv: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            lo_q    <= qneg_q ? (DATA_WIDTH'(0) - quo_nxt) : quo_nxt;
            hi_q    <= rneg_q ? (DATA_WIDTH'(0) - rem_nxt) : rem_nxt;
            state_q <= StDone;
          end
        end
        StDone: begin
          dz_q    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.stall_req     = 1'b0;
    bus.hilo_write_en = 1'b0;
    bus.hi_write_data = '0;
    bus.lo_write_data = '0;
    bus.div_by_zero   = 1'b0;
    if (!bus.flush) begin
      if (state_q == StDone) begin
        bus.hilo_write_en = 1'b1;
        bus.hi_write_data = hi_q;
        bus.lo_write_data = lo_q;
        bus.div_by_zero   = dz_q;
      end else if (state_q == StMul || state_q == StDiv || acc_mul || acc_div) begin
        bus.stall_req = 1'b1;
      end else if (acc_mthi) begin
        bus.hilo_write_en = 1'b1;
        bus.hi_write_data = bus.operand_a;
        bus.lo_write_data = bus.lo_in;
      end else if (acc_mtlo) begin
        bus.hilo_write_en = 1'b1;
        bus.hi_write_data = bus.hi_in;
        bus.lo_write_data = bus.operand_a;
      end
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomised self-checking bench for hilo_muldiv_ctrl against an arithmetic model.
module tb_hilo_muldiv_ctrl;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  hilo_muldiv_ctrl_if #(.DATA_WIDTH(32)) bus ();

  hilo_muldiv_ctrl #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Architectural result of one op: HI/LO values, stall cycles before the write, zero-divide flag.
  function automatic void model(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output int stalls, output bit dz);
    longint          sp, sa, sb, q, r;
    longint unsigned up;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    stalls = 0;
    if (code == OpMult) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      hi = sp[63:32]; lo = sp[31:0]; stalls = 2;
    end else if (code == OpMultu) begin
      up = {32'd0, a} * {32'd0, b};
      hi = up[63:32]; lo = up[31:0]; stalls = 2;
    end else if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF; stalls = 1; dz = 1'b1;
    end else begin
      if (code == OpDiv) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      lo = q[31:0]; hi = r[31:0]; stalls = 33;
    end
  endfunction

  // Presents a long op (held while stalled) and records what the DUT does until its write.
  task automatic run_long(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output bit seen, output logic [31:0] hi,
                          output logic [31:0] lo, output bit dz);
    int k = 0;
    stalls = 0; seen = 1'b0; hi = '0; lo = '0; dz = 1'b0;
    bus.op_valid  = 1'b1;
    bus.op_code   = code;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.hi_in     = $urandom;
    bus.lo_in     = $urandom;
    while (!seen && k < 60) begin
      @(negedge clk);
      if (bus.hilo_write_en === 1'b1) begin
        seen = 1'b1;
        hi = bus.hi_write_data;
        lo = bus.lo_write_data;
        dz = bus.div_by_zero;
        if (bus.stall_req !== 1'b0) stalls = stalls + 100;
      end else begin
        if (bus.stall_req === 1'b1) stalls++;
        @(posedge clk); #1;
      end
      k++;
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd0;
  endtask

  task automatic test_reset();
    bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.operand_a = '0; bus.operand_b = '0;
    bus.hi_in = 32'hDEAD_BEEF; bus.lo_in = 32'h1234_5678; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.stall_req, bus.hilo_write_en, bus.div_by_zero, bus.hi_write_data,
         bus.lo_write_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got stall=%b we=%b dz=%b hi=%h lo=%h, expected all 0",
               bus.stall_req, bus.hilo_write_en, bus.div_by_zero, bus.hi_write_data,
               bus.lo_write_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.stall_req, bus.hilo_write_en, bus.hi_write_data, bus.lo_write_data} !== '0) begin
        failures++;
        $display("FAIL idle_after_reset: got stall=%b we=%b hi=%h lo=%h, expected all 0",
                 bus.stall_req, bus.hilo_write_en, bus.hi_write_data, bus.lo_write_data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul(input int n);
    logic [2:0]  code;
    logic [31:0] a, b, hi, lo, ehi, elo;
    int          st, est;
    bit          seen, dz, edz;
    for (int i = 0; i < n; i++) begin
      if (i < 2) begin
        code = (i == 0) ? OpMult : OpMultu; a = 32'hFFFF_FFFE; b = 32'd3;
      end else begin
        code = ($urandom_range(0, 1) == 0) ? OpMult : OpMultu;
        a = $urandom; b = $urandom;
      end
      model(code, a, b, ehi, elo, est, edz);
      run_long(code, a, b, st, seen, hi, lo, dz);
      checks++;
      if (!seen || st != est || hi !== ehi || lo !== elo || dz !== edz) begin
        failures++;
        $display("FAIL mul code=%0d a=%h b=%h: got seen=%b stalls=%0d hi=%h lo=%h dz=%b, expected stalls=%0d hi=%h lo=%h dz=%b",
                 code, a, b, seen, st, hi, lo, dz, est, ehi, elo, edz);
      end
    end
  endtask

  task automatic test_div(input int n);
    logic [2:0]  code;
    logic [31:0] a, b, hi, lo, ehi, elo;
    int          st, est;
    bit          seen, dz, edz;
    for (int i = 0; i < n; i++) begin
      case (i)
        0: begin code = OpDiv;  a = 32'hFFFF_FFF9; b = 32'd2;         end
        1: begin code = OpDivu; a = 32'd100;       b = 32'd7;         end
        2: begin code = OpDiv;  a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin code = OpDivu; a = 32'd5;         b = 32'd0;         end
        4: begin code = OpDiv;  a = 32'h0000_0007; b = 32'hFFFF_FFFE; end
        5: begin code = OpDiv;  a = 32'hFFFF_FF00; b = 32'd0;         end
        default: begin
          code = ($urandom_range(0, 1) == 0) ? OpDiv : OpDivu;
          a = $urandom;
          case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 20);
            3:       b = 32'hFFFF_FFFF - $urandom_range(0, 20);
            default: b = $urandom;
          endcase
        end
      endcase
      model(code, a, b, ehi, elo, est, edz);
      run_long(code, a, b, st, seen, hi, lo, dz);
      checks++;
      if (!seen || st != est || hi !== ehi || lo !== elo || dz !== edz) begin
        failures++;
        $display("FAIL div code=%0d a=%h b=%h: got seen=%b stalls=%0d hi=%h lo=%h dz=%b, expected stalls=%0d hi=%h lo=%h dz=%b",
                 code, a, b, seen, st, hi, lo, dz, est, ehi, elo, edz);
      end
    end
  endtask

  task automatic test_mthi_mtlo(input int n);
    logic [31:0] a, hin, lin, ehi, elo;
    logic [2:0]  code;
    for (int i = 0; i < n; i++) begin
      code = (i % 2 == 0) ? OpMthi : OpMtlo;
      a   = (i < 2) ? 32'h1234_5678 : $urandom;
      hin = (i < 2) ? 32'h5555_0000 : $urandom;
      lin = (i < 2) ? 32'hAAAA_0000 : $urandom;
      ehi = (code == OpMthi) ? a : hin;
      elo = (code == OpMthi) ? lin : a;
      bus.op_valid = 1'b1; bus.op_code = code; bus.operand_a = a; bus.operand_b = $urandom;
      bus.hi_in = hin; bus.lo_in = lin;
      @(negedge clk);
      checks++;
      if (bus.hilo_write_en !== 1'b1 || bus.stall_req !== 1'b0 || bus.div_by_zero !== 1'b0 ||
          bus.hi_write_data !== ehi || bus.lo_write_data !== elo) begin
        failures++;
        $display("FAIL mthi_mtlo code=%0d: got we=%b stall=%b hi=%h lo=%h, expected we=1 stall=0 hi=%h lo=%h",
                 code, bus.hilo_write_en, bus.stall_req, bus.hi_write_data, bus.lo_write_data,
                 ehi, elo);
      end
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.hilo_write_en !== 1'b0 || bus.hi_write_data !== '0 || bus.lo_write_data !== '0) begin
        failures++;
        $display("FAIL mthi_mtlo_idle: got we=%b hi=%h lo=%h, expected 0 0 0",
                 bus.hilo_write_en, bus.hi_write_data, bus.lo_write_data);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    int          writes = 0;
    int          stalls = 0;
    int          st, est;
    bit          seen, dz, edz;
    logic [31:0] hi, lo, ehi, elo;
    bus.op_valid = 1'b1; bus.op_code = OpDivu; bus.operand_a = $urandom; bus.operand_b = 32'd9;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall_req !== 1'b0 || bus.hilo_write_en !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle: got stall=%b we=%b dz=%b, expected 0 0 0",
               bus.stall_req, bus.hilo_write_en, bus.div_by_zero);
    end
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op_code = 3'd0;
    repeat (40) begin
      @(negedge clk);
      if (bus.hilo_write_en === 1'b1) writes++;
      if (bus.stall_req === 1'b1) stalls++;
    end
    checks++;
    if (writes != 0 || stalls != 0) begin
      failures++;
      $display("FAIL flush_discard: got writes=%0d stalls=%0d, expected 0 0", writes, stalls);
    end
    @(posedge clk); #1;
    // Flush in the same cycle as an MTHI suppresses its write.
    bus.op_valid = 1'b1; bus.op_code = OpMthi; bus.operand_a = $urandom; bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.hilo_write_en !== 1'b0 || bus.hi_write_data !== '0) begin
      failures++;
      $display("FAIL flush_mthi: got we=%b hi=%h, expected 0 0",
               bus.hilo_write_en, bus.hi_write_data);
    end
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.op_valid = 1'b0;
    model(OpMult, 32'h0001_0003, 32'hFFFF_0005, ehi, elo, est, edz);
    run_long(OpMult, 32'h0001_0003, 32'hFFFF_0005, st, seen, hi, lo, dz);
    checks++;
    if (!seen || st != est || hi !== ehi || lo !== elo || dz !== edz) begin
      failures++;
      $display("FAIL mul_after_flush: got seen=%b stalls=%0d hi=%h lo=%h, expected stalls=%0d hi=%h lo=%h",
               seen, st, hi, lo, est, ehi, elo);
    end
  endtask

  task automatic test_reset_mid_div();
    int writes = 0;
    bus.op_valid = 1'b1; bus.op_code = OpDiv; bus.operand_a = $urandom; bus.operand_b = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; bus.op_valid = 1'b0; bus.op_code = 3'd0;
    #1;
    checks++;
    if ({bus.stall_req, bus.hilo_write_en, bus.div_by_zero, bus.hi_write_data,
         bus.lo_write_data} !== '0) begin
      failures++;
      $display("FAIL reset_mid_div: got stall=%b we=%b hi=%h lo=%h, expected all 0",
               bus.stall_req, bus.hilo_write_en, bus.hi_write_data, bus.lo_write_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.hilo_write_en === 1'b1 || bus.stall_req === 1'b1) writes++;
    end
    checks++;
    if (writes != 0) begin
      failures++;
      $display("FAIL reset_no_write: got active_cycles=%0d, expected 0", writes);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int          st, est;
    bit          seen, dz, edz;
    logic [31:0] hi, lo, ehi, elo, a;
    model(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ehi, elo, est, edz);
    run_long(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, seen, hi, lo, dz);
    checks++;
    if (!seen || st != est || hi !== ehi || lo !== elo) begin
      failures++;
      $display("FAIL b2b_mul: got seen=%b stalls=%0d hi=%h lo=%h, expected stalls=%0d hi=%h lo=%h",
               seen, st, hi, lo, est, ehi, elo);
    end
    // The cycle right after DONE carries a new op.
    a = $urandom;
    bus.op_valid = 1'b1; bus.op_code = OpMtlo; bus.operand_a = a; bus.hi_in = 32'h0BAD_F00D;
    @(negedge clk);
    checks++;
    if (bus.hilo_write_en !== 1'b1 || bus.stall_req !== 1'b0 ||
        bus.hi_write_data !== 32'h0BAD_F00D || bus.lo_write_data !== a) begin
      failures++;
      $display("FAIL b2b_mtlo: got we=%b stall=%b hi=%h lo=%h, expected we=1 stall=0 hi=0badf00d lo=%h",
               bus.hilo_write_en, bus.stall_req, bus.hi_write_data, bus.lo_write_data, a);
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op_code = 3'd0;
  endtask

  initial begin
    test_reset();
    test_mul(20);
    test_div(24);
    test_mthi_mtlo(6);
    test_flush();
    test_reset_mid_div();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Sequencer for every HI/LO-writing instruction in the execute stage: MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiplies take a registered two-stall-cycle path, and divides run an iterative 32-step restoring divider. While busy, the block holds the pipeline with `stall_req`, then issues one HI/LO write toward the HI/LO register file and its forwarding path. It sits beside the ALU in EX and is the only producer of HI/LO write data.

## Interface
- `DATA_WIDTH`, 32, operand and HI/LO width (`DATA_BUS`)
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `op_valid`  in  1  EX presents a HI/LO instruction this cycle
- `op_code`  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (ignored)
- `operand_a`  in  DATA_WIDTH  rs value / dividend / MTHI-MTLO source
- `operand_b`  in  DATA_WIDTH  rt value / divisor
- `hi_in`, `lo_in`  in  DATA_WIDTH  current forwarded HI/LO, used to keep the untouched half on MTHI/MTLO
- `flush`  in  1  cancel the in-flight op (exception / pipeline flush)
- `stall_req`  out  1  hold IF/ID/EX; EX keeps `op_*` and operands stable while high
- `hilo_write_en`  out  1  write strobe for HI and LO
- `hi_write_data`, `lo_write_data`  out  DATA_WIDTH  data to write
- `div_by_zero`  out  1  one-cycle pulse in the DONE cycle of a zero-divisor divide

## Operation
- States: IDLE, MUL, DIV, DONE. Registered: state, 5-bit iteration count, operand/partial-remainder/quotient regs, result regs, signed flags.
- IDLE, no flush, `op_valid`:
  - MULT/MULTU:
    - Capture operands; `stall_req`=1 combinationally.
    - Next state MUL.
  - DIV/DIVU:
    - Capture absolute values (signed DIV) or raw values (DIVU); record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a); `stall_req`=1.
    - If `operand_b`==0: next state DONE with HI=`operand_a`, LO=32'hFFFF_FFFF.
    - Otherwise: next state DIV with count 0.
  - MTHI:
    - Same cycle, combinational: `hilo_write_en`=1, HI=`operand_a`, LO=`lo_in`; no stall.
    - Stay IDLE.
  - MTLO: same as MTHI with LO=`operand_a`, HI=`hi_in`.
  - 000/111: no action.
- MUL:
  - `stall_req`=1.
  - Register the 64-bit product: signed for MULT, unsigned for MULTU. HI = product[63:32], LO = product[31:0].
  - Next state DONE.
- DIV:
  - `stall_req`=1.
  - One restoring step per cycle: shift {rem,quo} left, trial-subtract divisor, set quotient bit if non-negative.
  - After step 31 (count wraps 31→0), apply signs: negate quotient if its sign flag is set, negate remainder if its sign flag is set. Then LO = quotient, HI = remainder.
  - Next state DONE.
- DONE:
  - `stall_req`=0, `hilo_write_en`=1, outputs driven from the result regs.
  - `op_*` inputs are ignored.
  - Next state IDLE unconditionally.
- Data outputs are 0 whenever `hilo_write_en`=0.
- Flush:
  - Highest priority in any state: that cycle `stall_req`=0, `hilo_write_en`=0, `div_by_zero`=0, and nothing is accepted.
  - Next state IDLE; partial results are discarded.
- Boundary rules:
  - DIV 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0.
  - Remainder takes the dividend's sign.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, count 0, all data regs 0. All outputs 0 until the first op.
- The accepting cycle is T.
- MULT/MULTU: `stall_req` high in T and T+1; DONE (write) in T+2. Two stall cycles.
- DIV/DIVU, nonzero divisor: `stall_req` high in T..T+32 (DIV occupies T+1..T+32); DONE in T+33. 33 stall cycles.
- Zero divisor: `stall_req` high in T only; DONE in T+1 with `div_by_zero`=1.
- MTHI/MTLO: write in T; zero latency; no stall.
- The instruction leaves EX in the DONE cycle. The op presented in the cycle after DONE is treated as new.
- `rst_n` deasserting mid-stream: the block restarts in IDLE with no pending write.

## Test plan
- Reset, then MULT a=0xFFFF_FFFE (-2), b=3 → stall T,T+1; T+2 write HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. Same operands with MULTU → HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV a=-7 (0xFFFF_FFF9), b=2 → 33 stall cycles; T+33 write LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU 100/7 → LO=14, HI=2.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0. DIVU 5/0 → T+1 write HI=5, LO=0xFFFF_FFFF, `div_by_zero` pulse.
- MTHI a=0x1234_5678 with `lo_in`=0xAAAA_0000 → same-cycle write HI=0x1234_5678, LO=0xAAAA_0000, `stall_req`=0. MTLO mirrors this.
- DIVU started, `flush` at T+10 → `stall_req`=0 that cycle, IDLE next; no `hilo_write_en` ever asserted. A following MULT completes normally.
- `rst_n` pulsed low at T+5 of a DIV → outputs 0 immediately, IDLE; no write after release.
